// File: rtl/mem_wb_buffer.sv
// Writeback buffer between the data-memory unit and the CDB arbiter.
// Show-ahead FIFO of completed memory ops with valid/grant pop, almost-full stall and flush.
module mem_wb_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROB_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROB_BITS:0]         MEMU_ROBEN,
  input  logic [31:0]               MEMU_Result,
  input  logic                      MEMU_invalid_address,
  input  logic                      flush,
  input  logic                      CDB_grant,
  output logic                      WB_valid,
  output logic [ROB_BITS:0]         WB_ROBEN,
  output logic [31:0]               WB_Result,
  output logic                      WB_Exception,
  output logic                      WB_stall,
  output logic [$clog2(DEPTH):0]    WB_count,
  output logic                      WB_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ROB_BITS:0] tag_q [DEPTH];
  logic [31:0]       data_q[DEPTH];
  logic              exc_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  logic        push_req, full, head_valid, do_pop, do_push, drop;
  logic [31:0] push_data;

  assign push_req   = (MEMU_ROBEN != '0);
  assign head_valid = (count_q != '0);
  assign full       = (count_q == CntW'(DEPTH));
  assign do_pop     = head_valid & CDB_grant & ~flush;
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign do_push    = push_req & ~flush & (~full | do_pop);
  assign drop       = push_req & ~flush & full & ~do_pop;
  assign push_data  = MEMU_invalid_address ? 32'd0 : MEMU_Result;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CntW'(1);
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        exc_q[i]  <= 1'b0;
      end
    end else if (do_push) begin
      tag_q[wr_ptr_q]  <= MEMU_ROBEN;
      data_q[wr_ptr_q] <= push_data;
      exc_q[wr_ptr_q]  <= MEMU_invalid_address;
    end
  end

  always_comb begin
    WB_valid     = head_valid;
    WB_ROBEN     = head_valid ? tag_q[rd_ptr_q]  : '0;
    WB_Result    = head_valid ? data_q[rd_ptr_q] : '0;
    WB_Exception = head_valid ? exc_q[rd_ptr_q]  : 1'b0;
    WB_stall     = (count_q >= CntW'(DEPTH - 1));
    WB_count     = count_q;
    WB_overflow  = ovf_q;
  end

endmodule

// File: tb/tb_mem_wb_buffer.sv
// Self-checking bench for mem_wb_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_mem_wb_buffer;

  localparam int DEPTH    = 4;
  localparam int ROB_BITS = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ROB_BITS:0]      MEMU_ROBEN;
  logic [31:0]            MEMU_Result;
  logic                   MEMU_invalid_address;
  logic                   flush;
  logic                   CDB_grant;
  logic                   WB_valid;
  logic [ROB_BITS:0]      WB_ROBEN;
  logic [31:0]            WB_Result;
  logic                   WB_Exception;
  logic                   WB_stall;
  logic [$clog2(DEPTH):0] WB_count;
  logic                   WB_overflow;

  mem_wb_buffer #(.DEPTH(DEPTH), .ROB_BITS(ROB_BITS)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .MEMU_ROBEN           (MEMU_ROBEN),
    .MEMU_Result          (MEMU_Result),
    .MEMU_invalid_address (MEMU_invalid_address),
    .flush                (flush),
    .CDB_grant            (CDB_grant),
    .WB_valid             (WB_valid),
    .WB_ROBEN             (WB_ROBEN),
    .WB_Result            (WB_Result),
    .WB_Exception         (WB_Exception),
    .WB_stall             (WB_stall),
    .WB_count             (WB_count),
    .WB_overflow          (WB_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tag;
    int unsigned data;
    bit          exc;
  } op_t;

  op_t q[$];
  bit  m_ovf;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    op_t h;
    bit  v;
    v = (q.size() > 0);
    if (v) h = q[0];
    chk({ctx, ":valid"}, 32'(WB_valid), 32'(v));
    chk({ctx, ":roben"}, 32'(WB_ROBEN), v ? h.tag : 0);
    chk({ctx, ":result"}, WB_Result, v ? h.data : 0);
    chk({ctx, ":exc"}, 32'(WB_Exception), v ? 32'(h.exc) : 0);
    chk({ctx, ":count"}, 32'(WB_count), q.size());
    chk({ctx, ":stall"}, 32'(WB_stall), 32'(q.size() >= DEPTH - 1));
    chk({ctx, ":ovf"}, 32'(WB_overflow), 32'(m_ovf));
  endtask

  // Model of one clock edge, stated directly from the buffer's rules.
  task automatic model_edge(input int unsigned tag, input int unsigned data, input bit inv,
                            input bit grant, input bit fl);
    bit  popping;
    op_t o;
    if (fl) begin
      q.delete();
      return;
    end
    popping = grant && (q.size() > 0);
    if (tag != 0 && q.size() == DEPTH && !popping) m_ovf = 1'b1;
    else if (tag != 0) begin
      o.tag  = tag;
      o.data = inv ? 0 : data;
      o.exc  = inv;
      if (popping) void'(q.pop_front());
      q.push_back(o);
      return;
    end
    if (popping) void'(q.pop_front());
  endtask

  task automatic step(input string ctx, input int unsigned tag, input int unsigned data,
                      input bit inv, input bit grant, input bit fl);
    @(negedge clk);
    MEMU_ROBEN           = (ROB_BITS + 1)'(tag);
    MEMU_Result          = data;
    MEMU_invalid_address = inv;
    CDB_grant            = grant;
    flush                = fl;
    @(posedge clk);
    model_edge(tag, data, inv, grant, fl);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    MEMU_ROBEN = '0; MEMU_Result = '0; MEMU_invalid_address = 1'b0;
    CDB_grant = 1'b0; flush = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    MEMU_ROBEN = '0; MEMU_Result = '0; MEMU_invalid_address = 1'b0;
    CDB_grant = 1'b0; flush = 1'b0;
    m_ovf = 1'b0;
    #2;
    check_all("por");
    do_reset();

    // Single op, then grant drains it.
    step("t1_push", 5, 32'h1234, 0, 0, 0);
    chk("t1_tag_const", 32'(WB_ROBEN), 5);
    step("t1_pop", 0, 0, 0, 1, 0);
    chk("t1_empty_const", 32'(WB_valid), 0);

    // Invalid address zeroes data and flags exception.
    step("t2_inv", 3, 32'hDEAD, 1, 0, 0);
    chk("t2_res_const", WB_Result, 0);
    step("t2_pop", 0, 0, 0, 1, 0);

    // Back-pressure and overflow drop.
    for (int t = 1; t <= 4; t++) step("t3_fill", t, 32'h100 + t, 0, 0, 0);
    step("t3_drop", 5, 32'h105, 0, 0, 0);
    chk("t3_ovf_const", 32'(WB_overflow), 1);
    chk("t3_head_const", 32'(WB_ROBEN), 1);
    for (int t = 0; t < 4; t++) step("t3_drain", 0, 0, 0, 1, 0);

    // Full with simultaneous push and pop.
    do_reset();
    for (int t = 1; t <= 4; t++) step("t4_fill", t, 32'h200 + t, 0, 0, 0);
    step("t4_pushpop", 6, 32'h206, 0, 1, 0);
    chk("t4_ovf_const", 32'(WB_overflow), 0);
    for (int t = 0; t < 4; t++) step("t4_drain", 0, 0, 0, 1, 0);

    // Grant with empty buffer plus push: no pop, count 1.
    step("empty_pushgrant", 9, 32'h9, 0, 1, 0);
    step("empty_pop", 0, 0, 0, 1, 0);

    // Flush discards the same-edge push.
    step("t5_fill", 7, 32'h7, 0, 0, 0);
    step("t5_fill", 8, 32'h8, 0, 0, 0);
    step("t5_flush", 9, 32'h9, 0, 1, 1);
    chk("t5_cnt_const", 32'(WB_count), 0);
    step("t5_after", 0, 0, 0, 1, 0);

    // Asynchronous reset between edges.
    for (int t = 1; t <= 3; t++) step("t6_fill", t + 10, 32'h300 + t, 0, 0, 0);
    @(negedge clk);
    MEMU_ROBEN = '0; CDB_grant = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    check_all("t6_async");
    #1;
    rst = 1'b1;
    step("t6_after", 0, 0, 0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned tg;
      tg = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 31);
      step("rand", tg, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
